// File: rtl/display_scheduler_pkg.sv
// display_scheduler_pkg: shared display-driver codes, direction codes and scheduler states
package display_scheduler_pkg;
    localparam logic BAUDRATE_MODE = 1'b0;
    localparam logic DATA_MODE     = 1'b1;
    localparam logic [1:0] SEL_9600   = 2'd0;
    localparam logic [1:0] SEL_57600  = 2'd1;
    localparam logic [1:0] SEL_115200 = 2'd2;
    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;
    typedef enum logic {ST_BAUD = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/display_src_buf.sv
// display_src_buf: one-deep byte buffer with pending flag and overwrite detect
module display_src_buf (
    input  logic       src_clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       take,
    output logic       pend,
    output logic [7:0] data_buf,
    output logic       ovr
);
    // a strobe landing on an unconsumed byte loses that byte
    assign ovr = valid & pend & ~take;

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            data_buf <= '0;
        end else begin
            pend <= valid | (pend & ~take);
            if (valid) data_buf <= data;
        end
    end
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: shares the BCD display between baud selection, RX bytes and TX bytes
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter  int HOLD_CYCLES = 50_000_000,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       overrun_clr,
    output logic       mode,
    output logic       data_dir,
    output logic [7:0] msg,
    output logic       busy,
    output logic       overrun
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last_dir, last_dir_nx;
    logic             mode_nx, data_dir_nx, busy_nx, overrun_nx;
    logic [7:0]       msg_nx;
    logic             rx_pend, tx_pend, rx_ovr, tx_ovr, rx_take, tx_take;
    logic [7:0]       rx_buf, tx_buf;
    logic             any_pend, sel_tx, cnt_zero, load;

    display_src_buf u_rx (
        .src_clk (src_clk),
        .rst     (rst),
        .valid   (rx_valid),
        .data    (rx_data),
        .take    (rx_take),
        .pend    (rx_pend),
        .data_buf(rx_buf),
        .ovr     (rx_ovr)
    );

    display_src_buf u_tx (
        .src_clk (src_clk),
        .rst     (rst),
        .valid   (tx_valid),
        .data    (tx_data),
        .take    (tx_take),
        .pend    (tx_pend),
        .data_buf(tx_buf),
        .ovr     (tx_ovr)
    );

    // round robin on a tie: serve the direction not shown last
    assign any_pend = rx_pend | tx_pend;
    assign sel_tx   = tx_pend & (~rx_pend | (last_dir == DIR_RX));
    assign cnt_zero = (cnt == '0);
    assign load     = any_pend & ((state == ST_BAUD) | cnt_zero);
    assign rx_take  = load & ~sel_tx;
    assign tx_take  = load & sel_tx;

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BAUD;
            cnt      <= '0;
            last_dir <= DIR_TX;
            mode     <= BAUDRATE_MODE;
            data_dir <= DIR_RX;
            msg      <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            last_dir <= last_dir_nx;
            mode     <= mode_nx;
            data_dir <= data_dir_nx;
            msg      <= msg_nx;
            busy     <= busy_nx;
            overrun  <= overrun_nx;
        end
    end

    always_comb begin
        state_nx = (state == ST_BAUD) ? (any_pend ? ST_HOLD : ST_BAUD)
                                      : ((cnt_zero && !any_pend) ? ST_BAUD : ST_HOLD);
    end

    always_comb begin
        mode_nx     = mode;
        data_dir_nx = data_dir;
        msg_nx      = msg;
        busy_nx     = busy;
        cnt_nx      = cnt;
        last_dir_nx = last_dir;
        if (load) begin
            mode_nx     = DATA_MODE;
            data_dir_nx = sel_tx ? DIR_TX : DIR_RX;
            last_dir_nx = sel_tx ? DIR_TX : DIR_RX;
            msg_nx      = sel_tx ? tx_buf : rx_buf;
            cnt_nx      = CNT_LOAD;
            busy_nx     = 1'b1;
        end else if (state == ST_BAUD) begin
            mode_nx = BAUDRATE_MODE;
            msg_nx  = {6'b0, baud_sel};
            busy_nx = 1'b0;
        end else if (cnt_zero) begin
            busy_nx = 1'b0;
        end else begin
            cnt_nx = cnt - CNT_W'(1);
        end
        overrun_nx = rx_ovr | tx_ovr | (overrun & ~overrun_clr);
    end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed vector table plus reset-abort sequence for display_scheduler
module tb_display_scheduler;
    import display_scheduler_pkg::*;

    typedef struct {
        logic       rv;
        logic [7:0] rd;
        logic       tv;
        logic [7:0] td;
        logic       clr;
        logic [1:0] baud;
        logic [11:0] exp;
    } vec_t;

    logic       src_clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] baud_sel = SEL_9600;
    logic       rx_valid = 1'b0, tx_valid = 1'b0, overrun_clr = 1'b0;
    logic [7:0] rx_data = '0, tx_data = '0;
    logic       mode, data_dir, busy, overrun;
    logic [7:0] msg;
    vec_t       v[$];
    int         n_chk = 0;
    int         n_fail = 0;

    display_scheduler #(.HOLD_CYCLES(4)) dut (
        .src_clk    (src_clk),
        .rst        (rst),
        .baud_sel   (baud_sel),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .overrun_clr(overrun_clr),
        .mode       (mode),
        .data_dir   (data_dir),
        .msg        (msg),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 src_clk = ~src_clk;

    task automatic add(input int n, input logic rv, input logic [7:0] rd, input logic tv,
                       input logic [7:0] td, input logic clr, input logic [1:0] b,
                       input logic m, input logic d, input logic [7:0] ms,
                       input logic bz, input logic ov);
        for (int k = 0; k < n; k++) v.push_back('{rv, rd, tv, td, clr, b, {m, d, ms, bz, ov}});
    endtask

    task automatic chk(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {mode, data_dir, msg, busy, overrun};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got mode/dir/msg/busy/ovr=%b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                     name, act[11], act[10], act[9:2], act[1], act[0],
                     exp[11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge src_clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0;
        tx_valid = 1'b0;
        overrun_clr = 1'b0;
    endtask

    initial begin
        // baud display, simultaneous RX/TX tie, single RX
        add(1, 0, 8'h00, 0, 8'h00, 0, 2, 0, 0, 8'h02, 0, 0);
        add(1, 1, 8'h31, 1, 8'h32, 0, 2, 0, 0, 8'h02, 0, 0);
        add(4, 0, 8'h00, 0, 8'h00, 0, 2, 1, 0, 8'h31, 1, 0);
        add(4, 0, 8'h00, 0, 8'h00, 0, 2, 1, 1, 8'h32, 1, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 2, 1, 1, 8'h32, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 2, 0, 1, 8'h02, 0, 0);
        add(1, 1, 8'h41, 0, 8'h00, 0, 2, 0, 1, 8'h02, 0, 0);
        add(4, 0, 8'h00, 0, 8'h00, 0, 2, 1, 0, 8'h41, 1, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 2, 1, 0, 8'h41, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 2, 0, 0, 8'h02, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h01, 0, 0);
        // overwrite during hold, overrun clear, clear losing to a new overwrite
        add(1, 1, 8'h20, 0, 8'h00, 0, 1, 0, 0, 8'h01, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h20, 1, 0);
        add(1, 1, 8'h10, 0, 8'h00, 0, 1, 1, 0, 8'h20, 1, 0);
        add(1, 1, 8'h11, 0, 8'h00, 0, 1, 1, 0, 8'h20, 1, 1);
        add(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h20, 1, 1);
        add(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h11, 1, 1);
        add(1, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 8'h11, 1, 0);
        add(1, 1, 8'h12, 0, 8'h00, 0, 1, 1, 0, 8'h11, 1, 0);
        add(1, 1, 8'h13, 0, 8'h00, 1, 1, 1, 0, 8'h11, 1, 1);
        add(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h13, 1, 1);
        // strobe in the consuming cycle; baud change during hold shown only afterwards
        add(1, 1, 8'h50, 0, 8'h00, 1, 3, 1, 0, 8'h13, 1, 0);
        add(2, 0, 8'h00, 0, 8'h00, 0, 3, 1, 0, 8'h13, 1, 0);
        add(1, 1, 8'h51, 0, 8'h00, 0, 3, 1, 0, 8'h50, 1, 0);
        add(3, 0, 8'h00, 0, 8'h00, 0, 3, 1, 0, 8'h50, 1, 0);
        add(4, 0, 8'h00, 0, 8'h00, 0, 3, 1, 0, 8'h51, 1, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 3, 1, 0, 8'h51, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 3, 0, 0, 8'h03, 0, 0);

        #2 rst = 1'b1;
        step();
        step();
        chk("reset", {BAUDRATE_MODE, DIR_RX, 8'h00, 1'b0, 1'b0});
        rst = 1'b0;
        for (int i = 0; i < v.size(); i++) begin
            rx_valid    = v[i].rv;
            rx_data     = v[i].rd;
            tx_valid    = v[i].tv;
            tx_data     = v[i].td;
            overrun_clr = v[i].clr;
            baud_sel    = v[i].baud;
            step();
            chk($sformatf("vec[%0d]", i), v[i].exp);
        end

        // reset in the middle of the RX/TX tie hold aborts everything queued
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        baud_sel = SEL_115200;
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        tx_valid = 1'b1;
        tx_data  = 8'h32;
        step();
        idle_inputs();
        step();
        chk("abort_loaded", {DATA_MODE, DIR_RX, 8'h31, 1'b1, 1'b0});
        step();
        #1 rst = 1'b1;
        #1 chk("abort_async", {BAUDRATE_MODE, DIR_RX, 8'h00, 1'b0, 1'b0});
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("after_abort[%0d]", i), {BAUDRATE_MODE, DIR_RX, 8'h02, 1'b0, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
